bus_slave_mem: RTL and testbench

Memory-backed responder for the `bus_if` request/grant bus. It sits on the `slave` side of the bus opposite the bus master and holds a 256 x 32-bit register array. It answers each `req` with a single-cycle `gnt` after a programmable number of wait states. On the grant it commits writes and returns read data on `rdata`.

---
 rtl/bus_slave_mem_if.sv | 36 +++
 rtl/bus_slave_mem.sv | 121 ++++++++++++
 tb/tb_bus_slave_mem.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_mem_if.sv
// bus_if: request/grant bus between one master and one memory-backed slave.
//   req    master -> slave  request, held until the master sees gnt
//   wr_en  master -> slave  1 = write, 0 = read
//   addr   master -> slave  word address
//   wdata  master -> slave  write data
//   gnt    slave -> master  single-cycle grant pulse
//   rdata  slave -> master  read data, valid from the grant cycle onward
interface bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;

  modport slave (
    input  req,
    input  wr_en,
    input  addr,
    input  wdata,
    output gnt,
    output rdata
  );

  modport master (
    output req,
    output wr_en,
    output addr,
    output wdata,
    input  gnt,
    input  rdata
  );
endinterface

// File: rtl/bus_slave_mem.sv
// bus_slave_mem: memory-backed responder on the bus_if slave side.
// Holds a 2**ADDR_W x DATA_W register array and answers each request with
// a one-cycle grant after WAIT_CYCLES wait states. Writes commit and read
// data loads on the grant edge.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears state, outputs, memory)
//   bus    bus_if.slave (req, wr_en, addr, wdata in; gnt, rdata out)
module bus_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic  clk,
  input logic  rst_n,
  bus_if.slave bus
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              gnt_reg, gnt_next;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic grant_fire;
  logic mem_we;
  logic rd_load;

  // The edge that enters GRANT is the WAIT edge where the counter has run
  // out and the master still requests. With WAIT_CYCLES=0 the counter is
  // loaded with 0, so the request edge is followed directly by the grant
  // edge, giving the one-cycle minimum request-to-grant latency.
  assign grant_fire = (state_reg == WAIT) && bus.req && (cnt_reg == 4'd0);

  // State register, plus registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      gnt_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      if (rd_load) begin
        rdata_reg <= mem_reg[bus.addr];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          cnt_next   = WAIT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!bus.req) begin
          // Master withdrew: abort without grant or write.
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = GRANT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      GRANT: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        // A held request is ignored so it cannot start a second transaction.
        if (!bus.req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Output logic: command fields are sampled live on the grant edge only.
  always_comb begin
    gnt_next = grant_fire;
    mem_we   = grant_fire && bus.wr_en;
    rd_load  = grant_fire && !bus.wr_en;
  end

  // Memory array; reset clears every word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (mem_we) begin
      mem_reg[bus.addr] <= bus.wdata;
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.rdata = rdata_reg;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Testbench for bus_slave_mem. Four instances with WAIT_CYCLES = 2, 0, 1, 5
// share clock and reset; each has its own req line, command fields are shared.
module tb_bus_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        req_v   [4];
  logic        wr_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        gnt_v   [4];
  logic [31:0] rdata_v [4];

  int checks;
  int errors;

  // Wait states of each instance, written out by hand.
  int wc_tab [4] = '{2, 0, 1, 5};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 2 : (gi == 1) ? 0 : (gi == 2) ? 1 : 5;
      bus_if #(.ADDR_W(8), .DATA_W(32)) bi ();
      bus_slave_mem #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bi)
      );
      assign bi.req       = req_v[gi];
      assign bi.wr_en     = wr_en;
      assign bi.addr      = addr;
      assign bi.wdata     = wdata;
      assign gnt_v[gi]    = bi.gnt;
      assign rdata_v[gi]  = bi.rdata;
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one transaction on instance idx. Called #1 after a rising edge.
  // lat = edges from the request-sampling edge E0 to the grant edge
  // (-1 on timeout); extra = grant highs in the two cycles after the grant.
  task automatic txn(input int idx, input logic wr, input logic [7:0] a,
                     input logic [31:0] d, output int lat,
                     output logic [31:0] rd, output int extra);
    wr_en = wr;
    addr  = a;
    wdata = d;
    req_v[idx] = 1'b1;
    lat   = -1;
    rd    = '0;
    extra = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (gnt_v[idx]) begin
        lat = i - 1;
        rd  = rdata_v[idx];
        break;
      end
    end
    req_v[idx] = 1'b0;
    wr_en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (gnt_v[idx]) extra++;
    end
    $display("txn dut%0d wr=%0b addr=%02h wdata=%08h lat=%0d rdata=%08h extra=%0d",
             idx, wr, a, d, lat, rd, extra);
  endtask

  task automatic test_reset();
    int lat, extra;
    logic [31:0] rd;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (gnt_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_gnt: got %b expected 0", gnt_v[0]);
      end
      checks++;
      if (rdata_v[0] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata: got %08h expected 00000000", rdata_v[0]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 8'h00, 32'h0, lat, rd, extra);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL reset_rd00_lat: got %0d expected 3", lat);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd00_data: got %08h expected 00000000", rd);
    end
    txn(0, 1'b0, 8'hFF, 32'h0, lat, rd, extra);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdFF_data: got %08h expected 00000000", rd);
    end
  endtask

  task automatic test_default_latency();
    int lat, extra;
    logic [31:0] rd;
    txn(0, 1'b1, 8'h10, 32'hDEADBEEF, lat, rd, extra);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL dflt_wr_lat: got %0d expected 3", lat);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL dflt_wr_rdata_hold: got %08h expected 00000000", rd);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL dflt_wr_pulse: got %0d extra expected 0", extra);
    end
    txn(0, 1'b1, 8'h11, 32'h12345678, lat, rd, extra);
    txn(0, 1'b0, 8'h10, 32'h0, lat, rd, extra);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL dflt_rd_lat: got %0d expected 3", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL dflt_rd_data: got %08h expected deadbeef", rd);
    end
    txn(0, 1'b0, 8'h11, 32'h0, lat, rd, extra);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++;
      $display("FAIL dflt_rd11_data: got %08h expected 12345678", rd);
    end
  endtask

  task automatic test_param_sweep();
    int lat, extra;
    logic [31:0] rd;
    for (int idx = 1; idx < 4; idx++) begin
      txn(idx, 1'b1, 8'h60 + 8'(idx), 32'hC0DE0000 + 32'(idx), lat, rd, extra);
      checks++;
      if (lat !== wc_tab[idx] + 1) begin
        errors++;
        $display("FAIL sweep_wr_lat dut%0d: got %0d expected %0d", idx, lat, wc_tab[idx] + 1);
      end
      checks++;
      if (extra !== 0) begin
        errors++;
        $display("FAIL sweep_pulse dut%0d: got %0d extra expected 0", idx, extra);
      end
      txn(idx, 1'b0, 8'h60 + 8'(idx), 32'h0, lat, rd, extra);
      checks++;
      if (lat !== wc_tab[idx] + 1) begin
        errors++;
        $display("FAIL sweep_rd_lat dut%0d: got %0d expected %0d", idx, lat, wc_tab[idx] + 1);
      end
      checks++;
      if (rd !== 32'hC0DE0000 + 32'(idx)) begin
        errors++;
        $display("FAIL sweep_rd_data dut%0d: got %08h expected %08h", idx, rd, 32'hC0DE0000 + 32'(idx));
      end
    end
  endtask

  task automatic test_held_request();
    int lat, extra, pulses;
    logic [31:0] rd;
    wr_en = 1'b1;
    addr  = 8'h20;
    wdata = 32'h1;
    req_v[0] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (gnt_v[0]) begin
        lat = i - 1;
        break;
      end
    end
    wdata  = 32'h2;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (gnt_v[0]) pulses++;
    end
    req_v[0] = 1'b0;
    wr_en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (gnt_v[0]) pulses++;
    end
    $display("txn dut0 held write addr=20 lat=%0d extra_pulses=%0d", lat, pulses);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL held_lat: got %0d expected 3", lat);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL held_pulses: got %0d extra expected 0", pulses);
    end
    txn(0, 1'b0, 8'h20, 32'h0, lat, rd, extra);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL held_data: got %08h expected 00000001", rd);
    end
  endtask

  task automatic test_abort_and_late_cmd();
    int lat, extra, pulses;
    logic [31:0] rd;
    // Abort: request withdrawn during WAIT.
    wr_en = 1'b1;
    addr  = 8'h40;
    wdata = 32'h0000AAAA;
    req_v[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    wr_en = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (gnt_v[0]) pulses++;
    end
    $display("txn dut0 aborted write addr=40 pulses=%0d", pulses);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_gnt: got %0d pulses expected 0", pulses);
    end
    txn(0, 1'b0, 8'h40, 32'h0, lat, rd, extra);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL abort_mem: got %08h expected 00000000", rd);
    end
    // Late command: wr_en cleared one cycle after the request edge.
    txn(0, 1'b1, 8'h50, 32'h11111111, lat, rd, extra);
    wr_en = 1'b1;
    addr  = 8'h50;
    wdata = 32'h99999999;
    req_v[0] = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (gnt_v[0]) begin
        lat = i;
        rd  = rdata_v[0];
        break;
      end
    end
    req_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("txn dut0 late-cmd read addr=50 lat=%0d rdata=%08h", lat, rd);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL late_lat: got %0d expected 3", lat);
    end
    checks++;
    if (rd !== 32'h11111111) begin
      errors++;
      $display("FAIL late_rdata: got %08h expected 11111111", rd);
    end
    txn(0, 1'b0, 8'h50, 32'h0, lat, rd, extra);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++;
      $display("FAIL late_mem: got %08h expected 11111111", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, extra;
    logic [31:0] rd;
    txn(1, 1'b1, 8'h70, 32'hA5A5A5A5, lat, rd, extra);
    txn(1, 1'b0, 8'h70, 32'h0, lat, rd, extra);
    checks++;
    if (lat !== 1 || rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_rd70: got lat=%0d data=%08h expected lat=1 data=a5a5a5a5", lat, rd);
    end
    txn(1, 1'b1, 8'h71, 32'h5A5A5A5A, lat, rd, extra);
    checks++;
    if (lat !== 1 || rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_wr71: got lat=%0d rdata=%08h expected lat=1 rdata=a5a5a5a5", lat, rd);
    end
    txn(1, 1'b0, 8'h71, 32'h0, lat, rd, extra);
    checks++;
    if (lat !== 1 || rd !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL b2b_rd71: got lat=%0d data=%08h expected lat=1 data=5a5a5a5a", lat, rd);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, extra, pulses;
    logic [31:0] rd;
    wr_en = 1'b1;
    addr  = 8'h30;
    wdata = 32'h55;
    req_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_n  = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (gnt_v[0]) pulses++;
    end
    req_v[0] = 1'b0;
    wr_en = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (gnt_v[0]) pulses++;
    end
    $display("txn dut0 write addr=30 interrupted by reset pulses=%0d", pulses);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rstmid_gnt: got %0d pulses expected 0", pulses);
    end
    txn(0, 1'b0, 8'h30, 32'h0, lat, rd, extra);
    checks++;
    if (lat !== 3 || rd !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_mem: got lat=%0d data=%08h expected lat=3 data=00000000", lat, rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    addr   = 8'h0;
    wdata  = 32'h0;
    for (int i = 0; i < 4; i++) req_v[i] = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_default_latency();
    test_param_sweep();
    test_held_request();
    test_abort_and_late_cmd();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
